dcache_ctrl_param: RTL

- Parametrised successor to the data-cache controller. It sits between the pipeline memory stage, the data cache array and the block-wide memory port.
- Supports configurable word and block geometry, selectable write-back or write-through policy, and a one-entry write-through buffer.
- Includes saturating hit, miss and writeback performance counters.
- Stalls the pipeline on misses and on write-buffer conflicts.

---
 rtl/dcache_ctrl_param.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/dcache_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module  : dcache_ctrl_param
// Brief   : Parametrised data-cache controller (write-back / write-through,
//           one-entry write buffer, saturating hit/miss/writeback counters).
// Rev     : 1.0  initial release
// ============================================================================
module dcache_ctrl_param #(
    parameter int BADDR_W       = 26,
    parameter int WORD_BYTES    = 4,
    parameter int BLOCK_WORDS   = 8,
    parameter int WRITE_THROUGH = 0,
    parameter int CNT_W         = 32,
    localparam int WOFF_W       = $clog2(BLOCK_WORDS),
    localparam int WORD_W       = 8 * WORD_BYTES,
    localparam int BE_W         = WORD_BYTES * BLOCK_WORDS,
    localparam int BLK_W        = WORD_W * BLOCK_WORDS
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      i_ren,
    input  logic                      i_wen,
    input  logic [BADDR_W+WOFF_W-1:0] i_addr,
    input  logic [WORD_BYTES-1:0]     i_byte_sel,
    input  logic [WORD_W-1:0]         i_din,
    output logic                      o_stall,
    output logic [WORD_W-1:0]         o_dout,
    input  logic                      i_cache_hit,
    input  logic                      i_cache_dirty,
    input  logic [BADDR_W-1:0]        i_cache_victim_addr,
    input  logic [BLK_W-1:0]          i_cache_dout,
    output logic                      o_cache_en,
    output logic                      o_cache_wen,
    output logic                      o_cache_fill,
    output logic                      o_cache_set_dirty,
    output logic [BE_W-1:0]           o_cache_byte_en,
    output logic [BADDR_W-1:0]        o_cache_block_addr,
    output logic [BLK_W-1:0]          o_cache_din,
    output logic                      o_mem_ren,
    output logic                      o_mem_wen,
    output logic [BADDR_W-1:0]        o_mem_block_addr,
    output logic [BLK_W-1:0]          o_mem_din,
    input  logic [BLK_W-1:0]          i_mem_dout,
    input  logic                      i_mem_read_ready,
    input  logic                      i_mem_write_done,
    output logic [CNT_W-1:0]          o_hit_count,
    output logic [CNT_W-1:0]          o_miss_count,
    output logic [CNT_W-1:0]          o_wb_count
);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_WRITEBACK = 3'd1;
    localparam logic [2:0] c_REFILL    = 3'd2;
    localparam logic [2:0] c_FILL      = 3'd3;
    localparam logic [2:0] c_WTHRU     = 3'd4;

    localparam bit              c_WT      = (WRITE_THROUGH != 0);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [2:0]         r_state;
    logic [2:0]         w_next;
    logic               r_replay;
    // Shared line buffer: victim line, refill data or write-through block.
    logic [BLK_W-1:0]   r_blk;
    logic [BADDR_W-1:0] r_blk_addr;
    logic [CNT_W-1:0]   r_hit;
    logic [CNT_W-1:0]   r_miss;
    logic [CNT_W-1:0]   r_wb;

    logic               w_req;
    logic               w_ack;
    logic               w_miss;
    logic [BADDR_W-1:0] w_baddr;
    logic [WOFF_W-1:0]  w_off;
    logic [BE_W-1:0]    w_be_st;
    logic [BLK_W-1:0]   w_rep;
    logic [BLK_W-1:0]   w_merged;
    logic [WORD_W-1:0]  w_word;

    assign w_req   = i_ren | i_wen;
    assign w_baddr = i_addr[WOFF_W +: BADDR_W];
    assign w_off   = i_addr[WOFF_W-1:0];
    assign w_be_st = {{(BE_W-WORD_BYTES){1'b0}}, i_byte_sel} << (WORD_BYTES * w_off);
    assign w_rep   = {BLOCK_WORDS{i_din}};
    assign w_word  = i_cache_dout[WORD_W*w_off +: WORD_W];
    assign w_ack   = (r_state == c_IDLE) && w_req && i_cache_hit;
    assign w_miss  = (r_state == c_IDLE) && w_req && !i_cache_hit;

    for (genvar b = 0; b < BE_W; b++) begin : g_merge
        assign w_merged[8*b +: 8] = w_be_st[b] ? w_rep[8*b +: 8] : i_cache_dout[8*b +: 8];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_req) begin
                    if (!i_cache_hit) begin
                        w_next = (i_cache_dirty && !c_WT) ? c_WRITEBACK : c_REFILL;
                    end else if (i_wen && c_WT) begin
                        w_next = c_WTHRU;
                    end
                end
            end
            c_WRITEBACK: if (i_mem_write_done) w_next = c_REFILL;
            c_REFILL:    if (i_mem_read_ready) w_next = c_FILL;
            c_FILL:      w_next = c_IDLE;
            c_WTHRU:     if (i_mem_write_done) w_next = c_IDLE;
            default:     w_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_blk      <= '0;
            r_blk_addr <= '0;
            r_replay   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_miss && i_cache_dirty && !c_WT) begin
                        r_blk      <= i_cache_dout;
                        r_blk_addr <= i_cache_victim_addr;
                    end else if (w_ack && i_wen && c_WT) begin
                        r_blk      <= w_merged;
                        r_blk_addr <= w_baddr;
                    end
                end
                c_REFILL: if (i_mem_read_ready) r_blk <= i_mem_dout;
                default: ;
            endcase
            if (r_state == c_FILL) begin
                r_replay <= 1'b1;
            end else if (w_ack) begin
                r_replay <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_hit  <= '0;
            r_miss <= '0;
            r_wb   <= '0;
        end else begin
            if (w_ack && !r_replay && r_hit != c_CNT_MAX) r_hit <= r_hit + CNT_W'(1);
            if (w_miss && r_miss != c_CNT_MAX) r_miss <= r_miss + CNT_W'(1);
            if (r_state == c_WRITEBACK && i_mem_write_done && r_wb != c_CNT_MAX) begin
                r_wb <= r_wb + CNT_W'(1);
            end
        end
    end

    always_comb begin
        o_stall            = 1'b0;
        o_dout             = '0;
        o_cache_en         = 1'b0;
        o_cache_wen        = 1'b0;
        o_cache_fill       = 1'b0;
        o_cache_set_dirty  = 1'b0;
        o_cache_byte_en    = '0;
        o_cache_block_addr = '0;
        o_cache_din        = '0;
        o_mem_ren          = 1'b0;
        o_mem_wen          = 1'b0;
        o_mem_block_addr   = '0;
        o_mem_din          = '0;
        // Everything is forced low while reset is held, including the pass-through paths.
        if (reset) begin
            o_dout = w_word;
            if (r_state != c_WTHRU) o_cache_block_addr = w_baddr;
            case (r_state)
                c_IDLE: begin
                    if (w_req) begin
                        if (i_cache_hit) begin
                            o_cache_en = 1'b1;
                            if (i_wen) begin
                                o_cache_wen       = 1'b1;
                                o_cache_set_dirty = !c_WT;
                                o_cache_byte_en   = w_be_st;
                                o_cache_din       = w_rep;
                            end
                        end else begin
                            o_stall = 1'b1;
                        end
                    end
                end
                c_WRITEBACK: begin
                    o_stall          = 1'b1;
                    o_mem_wen        = 1'b1;
                    o_mem_block_addr = r_blk_addr;
                    o_mem_din        = r_blk;
                end
                c_REFILL: begin
                    o_stall          = 1'b1;
                    o_mem_ren        = 1'b1;
                    o_mem_block_addr = w_baddr;
                end
                c_FILL: begin
                    o_stall         = 1'b1;
                    o_cache_en      = 1'b1;
                    o_cache_wen     = 1'b1;
                    o_cache_fill    = 1'b1;
                    o_cache_byte_en = '1;
                    o_cache_din     = r_blk;
                end
                c_WTHRU: begin
                    o_stall          = w_req;
                    o_mem_wen        = 1'b1;
                    o_mem_block_addr = r_blk_addr;
                    o_mem_din        = r_blk;
                end
                default: ;
            endcase
        end
    end

    assign o_hit_count  = r_hit;
    assign o_miss_count = r_miss;
    assign o_wb_count   = r_wb;

endmodule
`default_nettype wire
